// File: rtl/dccm_req_seq_if.sv
// Request/response handshake bundle between a requester and the DCCM sequencer.
// Request is accepted on valid & ready; response is held until resp_ready.
interface dccm_req_seq_if #(
   parameter int AW = 10
) ();
   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [AW-1:0] req_addr;
   logic [31:0]   req_wdata;
   logic [3:0]    req_mask;
   logic          resp_valid;
   logic          resp_ready;
   logic          resp_write;
   logic [31:0]   resp_rdata;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_mask, resp_ready,
      input  req_ready, resp_valid, resp_write, resp_rdata
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_mask, resp_ready,
      output req_ready, resp_valid, resp_write, resp_rdata
   );
endinterface

// File: rtl/dccm_req_seq.sv
// Single-outstanding DCCM request sequencer with post-reset zero-fill and byte-masked
// read-modify-write. Latency: full/zero-mask write 2, read 3, partial write 4 cycles.
module dccm_req_seq #(
   parameter int AW      = 10,
   parameter bit INIT_EN = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   dccm_req_seq_if.slave bus,
   output logic          init_done,
   output logic          dccm_wren,
   output logic          dccm_rden,
   output logic [AW-1:0] dccm_wr_addr,
   output logic [AW-1:0] dccm_rd_addr_lo,
   output logic [AW-1:0] dccm_rd_addr_hi,
   output logic [31:0]   dccm_wr_data,
   input  logic [31:0]   dccm_rd_data_lo,
   input  logic [31:0]   dccm_rd_data_hi
);

   typedef enum logic [2:0] {
      S_INIT,
      S_IDLE,
      S_ISSUE,
      S_CAPT,
      S_WRB,
      S_RESP
   } state_t;

   localparam state_t RST_STATE = INIT_EN ? S_INIT : S_IDLE;

   state_t        state_q, state_d;
   logic [AW-1:0] cnt_q;
   logic          done_q;
   logic          wr_q;
   logic [AW-1:0] addr_q;
   logic [31:0]   wdata_q;
   logic [3:0]    mask_q;
   logic [31:0]   rdata_q;
   logic [31:0]   merged;

   logic          req_ready_c;
   logic          resp_valid_c;
   logic          resp_write_c;
   logic [31:0]   resp_rdata_c;
   logic          wren_c;
   logic          rden_c;
   logic [AW-1:0] wr_addr_c;
   logic [AW-1:0] rd_addr_c;
   logic [31:0]   wr_data_c;

   logic          unused_rd_hi;
   assign unused_rd_hi = ^dccm_rd_data_hi;

   always_comb begin
      merged = '0;
      for (int i = 0; i < 4; i++) begin
         merged[8*i +: 8] = mask_q[i] ? wdata_q[8*i +: 8] : dccm_rd_data_lo[8*i +: 8];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RST_STATE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         mask_q  <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            S_INIT: begin
               cnt_q <= cnt_q + 1'b1;
               if (&cnt_q) begin
                  done_q <= 1'b1;
               end
            end
            S_IDLE: begin
               if (bus.req_valid) begin
                  wr_q    <= bus.req_write;
                  addr_q  <= bus.req_addr;
                  wdata_q <= bus.req_wdata;
                  mask_q  <= bus.req_mask;
                  rdata_q <= '0;
               end
            end
            S_CAPT: begin
               // Partial writes reuse the write-data register to hold the merged word.
               if (wr_q) begin
                  wdata_q <= merged;
               end else begin
                  rdata_q <= dccm_rd_data_lo;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d      = state_q;
      req_ready_c  = 1'b0;
      resp_valid_c = 1'b0;
      resp_write_c = 1'b0;
      resp_rdata_c = '0;
      wren_c       = 1'b0;
      rden_c       = 1'b0;
      wr_addr_c    = '0;
      rd_addr_c    = '0;
      wr_data_c    = '0;
      case (state_q)
         S_INIT: begin
            wren_c    = 1'b1;
            wr_addr_c = cnt_q;
            if (&cnt_q) begin
               state_d = S_IDLE;
            end
         end
         S_IDLE: begin
            req_ready_c = 1'b1;
            if (bus.req_valid) begin
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (wr_q && mask_q == 4'hF) begin
               wren_c    = 1'b1;
               wr_addr_c = addr_q;
               wr_data_c = wdata_q;
               state_d   = S_RESP;
            end else if (wr_q && mask_q == 4'h0) begin
               state_d = S_RESP;
            end else begin
               rden_c    = 1'b1;
               rd_addr_c = addr_q;
               state_d   = S_CAPT;
            end
         end
         S_CAPT: begin
            state_d = wr_q ? S_WRB : S_RESP;
         end
         S_WRB: begin
            wren_c    = 1'b1;
            wr_addr_c = addr_q;
            wr_data_c = wdata_q;
            state_d   = S_RESP;
         end
         S_RESP: begin
            resp_valid_c = 1'b1;
            resp_write_c = wr_q;
            resp_rdata_c = rdata_q;
            if (bus.resp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = RST_STATE;
      endcase
      // The reset state is INIT, which would otherwise strobe memory while rst is held.
      if (rst) begin
         req_ready_c  = 1'b0;
         resp_valid_c = 1'b0;
         resp_write_c = 1'b0;
         resp_rdata_c = '0;
         wren_c       = 1'b0;
         rden_c       = 1'b0;
         wr_addr_c    = '0;
         rd_addr_c    = '0;
         wr_data_c    = '0;
      end
   end

   assign bus.req_ready   = req_ready_c;
   assign bus.resp_valid  = resp_valid_c;
   assign bus.resp_write  = resp_write_c;
   assign bus.resp_rdata  = resp_rdata_c;
   assign dccm_wren       = wren_c;
   assign dccm_rden       = rden_c;
   assign dccm_wr_addr    = wr_addr_c;
   assign dccm_rd_addr_lo = rd_addr_c;
   assign dccm_rd_addr_hi = rd_addr_c;
   assign dccm_wr_data    = wr_data_c;
   assign init_done       = INIT_EN ? done_q : 1'b1;

endmodule

// File: doc/dccm_req_seq.md
DCCM_REQ_SEQ -- requirements
Module: dccm_req_seq

Interface
REQ-001 SHALL have parameter AW, default 10, meaning DCCM word-address width (depth 2^AW words).
REQ-002 SHALL have parameter INIT_EN, default 1, meaning zero-fill the whole DCCM after reset before accepting requests.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  in  1  request present.
REQ-006 SHALL have port req_ready  out  1  request accepted when both req_valid and req_ready are high.
REQ-007 SHALL have port req_write  in  1  1 = write, 0 = read.
REQ-008 SHALL have port req_addr  in  AW  word address.
REQ-009 SHALL have port req_wdata  in  32  write data.
REQ-010 SHALL have port req_mask  in  4  byte enables; bit i covers wdata[8i+7:8i].
REQ-011 SHALL have port resp_valid  out  1  response present; held until resp_ready.
REQ-012 SHALL have port resp_ready  in  1  response consumed.
REQ-013 SHALL have port resp_write  out  1  response belongs to a write (ack) when 1.
REQ-014 SHALL have port resp_rdata  out  32  read data; 0 for write responses.
REQ-015 SHALL have port init_done  out  1  zero-fill complete (or INIT_EN=0).
REQ-016 SHALL have ports dccm_wren, dccm_rden  out  1 each  memory write and read strobes.
REQ-017 SHALL have ports dccm_wr_addr, dccm_rd_addr_lo, dccm_rd_addr_hi  out  AW each  memory addresses; rd_addr_hi always equals rd_addr_lo.
REQ-018 SHALL have port dccm_wr_data  out  32  memory write data.
REQ-019 SHALL have ports dccm_rd_data_lo, dccm_rd_data_hi  in  32 each  memory read data, valid the cycle after dccm_rden; rd_data_hi is ignored.

Function
REQ-020 SHALL implement states INIT, IDLE, ISSUE, CAPT, WRB, RESP; after reset the state SHALL be INIT if INIT_EN=1, else IDLE.
REQ-021 INIT: each cycle drive dccm_wren=1, dccm_wr_addr=init counter, dccm_wr_data=0; counter starts at 0, increments by 1; after the write to address 2^AW-1, go to IDLE and set init_done=1 the next cycle.
REQ-022 req_ready SHALL be 1 only in IDLE; req_valid in any other state SHALL be ignored and no state captured.
REQ-023 On acceptance (cycle T), write, addr, wdata, mask SHALL be registered and the state SHALL go to ISSUE.
REQ-024 ISSUE, full write (mask=4'hF): dccm_wren=1 with registered addr/wdata at T+1; go to RESP; resp_valid=1 from T+2.
REQ-025 ISSUE, zero-mask write (mask=4'h0): no memory strobe; go to RESP; resp_valid=1 from T+2.
REQ-026 ISSUE, read or partial write: dccm_rden=1, dccm_rd_addr_lo=addr at T+1; go to CAPT.
REQ-027 CAPT (T+2), read: register dccm_rd_data_lo into resp_rdata; go to RESP; resp_valid=1 from T+3.
REQ-028 CAPT (T+2), partial write: register merged word, byte i = mask[i] ? wdata byte i : rd_data_lo byte i; go to WRB.
REQ-029 WRB (T+3): dccm_wren=1, wr_addr=addr, wr_data=merged word; go to RESP; resp_valid=1 from T+4.
REQ-030 RESP: resp_valid, resp_write, resp_rdata SHALL stay stable until resp_valid and resp_ready are both high; the state SHALL then return to IDLE and resp_valid SHALL be 0 the next cycle.
REQ-031 At most one request SHALL be outstanding; a request SHALL NOT be accepted in the same cycle its predecessor's response is consumed.
REQ-032 dccm_wren and dccm_rden SHALL never be 1 in the same cycle; when no strobe is active, memory address and data outputs SHALL be 0.

Reset
REQ-033 On rst assertion, regardless of state, the block SHALL immediately drive req_ready=0, resp_valid=0, resp_write=0, resp_rdata=0, dccm_wren=0, dccm_rden=0, all addresses and wr_data=0, init_done=0 (1 if INIT_EN=0), and clear the init counter.
REQ-034 On rst deassertion the block SHALL restart from the REQ-020 state; an in-flight request or response SHALL be discarded, and an interrupted INIT sweep SHALL restart at address 0.

Verification
REQ-035 AW=3, INIT_EN=1, release reset -> wren high 8 consecutive cycles, addrs 0..7, data 0; init_done=1 the cycle after the state reaches IDLE; req_ready=1 in IDLE.
REQ-036 Write addr 5, data 0xDEADBEEF, mask 0xF, then read addr 5 -> single wren at T+1; write ack at T+2; read resp at T+3 with rdata 0xDEADBEEF.
REQ-037 Memory at addr 2 = 0x11223344, write 0xAABBCCDD mask 0x5 -> rden T+1, wren T+3 with data 0x11BB33DD, ack at T+4.
REQ-038 Mask 0x0 write -> no wren/rden, ack at T+2; hold resp_ready=0 for 5 cycles -> resp stable, req_ready=0 throughout.
REQ-039 Assert rst during WRB of a partial write -> no wren that cycle onward; after release, INIT restarts at address 0 and resp_valid stays 0.
